instr_fetch: RTL

- Consumer end of the program counter's fetch address: takes the current PC and issues read requests to instruction memory over a valid/ready AR/R channel pair.
- Buffers returned instructions and presents them to decode with a valid/ready handshake, each tagged with its PC.
- Supports pipeline flush on redirect (jump/branch): in-flight responses are discarded.
- Sits between program_counter and the decode stage.

---
 rtl/instr_fetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front end: turns the program counter into read requests on
// a valid/ready AR/R channel pair and delivers returned words, tagged with their
// PC and a fault flag, to decode. A redirect flushes everything buffered and
// arranges for every response still in flight to be discarded on arrival.
module instr_fetch #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] i_pc_addr,
  input  logic            i_pc_valid,
  output logic            o_pc_ack,
  input  logic            i_flush,
  output logic            o_imem_arvalid,
  input  logic            i_imem_arready,
  output logic [XLEN-1:0] o_imem_araddr,
  input  logic            i_imem_rvalid,
  output logic            o_imem_rready,
  input  logic [ILEN-1:0] i_imem_rdata,
  input  logic [1:0]      i_imem_rresp,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [ILEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  output logic            o_if_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [ILEN-1:0] NOP     = ILEN'(32'h0000_0013);

  // requests accepted but not yet answered, responses still to be thrown away,
  // and words waiting for decode
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;

  logic [XLEN-1:0] tag_pc  [DEPTH];
  logic            tag_mis [DEPTH];
  logic [AW-1:0]   tag_wr;
  logic [AW-1:0]   tag_rd;

  logic [ILEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic            q_fault [DEPTH];
  logic [AW-1:0]   q_wr;
  logic [AW-1:0]   q_rd;

  logic            rready_q;
  logic            credit;
  logic            accept;
  logic            beat;
  logic            dropping;
  logic            push;
  logic            pop;
  logic            resp_fault;

  // Every accepted PC owns one slot until decode takes it, so the instruction
  // buffer can never overflow and R can always be accepted.
  assign credit     = (inflight + fifo_count) < DEPTH_C;
  assign accept     = rstn & i_pc_valid & credit & ~i_flush &
                      (~o_imem_arvalid | i_imem_arready);
  assign o_pc_ack   = accept;
  assign beat       = i_imem_rvalid & rready_q & (inflight != '0);
  assign dropping   = drop_cnt != '0;
  assign push       = beat & ~dropping & ~i_flush;
  assign pop        = (fifo_count != '0) & i_if_ready & ~i_flush;
  assign resp_fault = tag_mis[tag_rd] | (i_imem_rresp != 2'b00);

  assign o_imem_rready = rready_q;
  assign o_if_valid    = fifo_count != '0;
  assign o_if_instr    = q_instr[q_rd];
  assign o_if_pc       = q_pc[q_rd];
  assign o_if_fault    = q_fault[q_rd];

  // AR channel: a request, once raised, holds until the memory takes it, even across a flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_imem_arvalid <= 1'b0;
      o_imem_araddr  <= '0;
      rready_q       <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      if (accept) begin
        o_imem_arvalid <= 1'b1;
        o_imem_araddr  <= {i_pc_addr[XLEN-1:2], 2'b00};
      end else if (i_imem_arready) begin
        o_imem_arvalid <= 1'b0;
      end
    end
  end

  // Tag FIFO and in-flight/drop bookkeeping; a flush marks all remaining in-flight responses for discard
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_pc[i]  <= '0;
        tag_mis[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        tag_pc[tag_wr]  <= i_pc_addr;
        tag_mis[tag_wr] <= i_pc_addr[1:0] != 2'b00;
        tag_wr          <= tag_wr + 1'b1;
      end
      if (beat) tag_rd <= tag_rd + 1'b1;
      inflight <= inflight + CW'(accept) - CW'(beat);
      if (i_flush)
        drop_cnt <= inflight - CW'(beat);
      else if (beat && dropping)
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // Instruction FIFO; its head register drives decode directly
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_wr       <= '0;
      q_rd       <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_fault[i] <= 1'b0;
      end
    end else if (i_flush) begin
      q_wr       <= '0;
      q_rd       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        q_instr[q_wr] <= resp_fault ? NOP : i_imem_rdata;
        q_pc[q_wr]    <= tag_pc[tag_rd];
        q_fault[q_wr] <= resp_fault;
        q_wr          <= q_wr + 1'b1;
      end
      if (pop) q_rd <= q_rd + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // A response with nothing outstanding is a memory protocol violation
  always_ff @(posedge clk) begin
    if (rstn && i_imem_rvalid && rready_q) assert (inflight != '0);
  end

endmodule
